// File: rtl/matrix_row_accumulate_if.sv
// ---------------------------------------------------------------------------
// matrix_row_accumulate_if
//
// Stream bundle for matrix_row_accumulate. It carries the element input stream
// from the transpose stage and the row-sum output stream to the next stage.
//
// Parameters
//   SIZE        matrix dimension; only used here to size the sum
//   DATA_WIDTH  input element width
//   OUT_WIDTH   (local) row-sum width, DATA_WIDTH + $clog2(SIZE)
//
// Signals
//   in_tdata   [DATA_WIDTH]  element
//   in_tvalid                element valid
//   in_tlast                 last element of a matrix
//   in_tready                element accepted when in_tvalid && in_tready
//   out_tdata  [OUT_WIDTH]   row sum
//   out_tvalid               row sum valid
//   out_tlast                sum of the last row of a matrix
//   out_tready               downstream ready
//
// Modports
//   master  upstream/downstream environment (drives in_*, out_tready)
//   slave   the accumulator itself (drives in_tready, out_tdata/valid/last)
// ---------------------------------------------------------------------------
interface matrix_row_accumulate_if #(
  parameter int SIZE       = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int OUT_WIDTH = DATA_WIDTH + $clog2(SIZE);

  logic [DATA_WIDTH-1:0] in_tdata;
  logic                  in_tvalid;
  logic                  in_tlast;
  logic                  in_tready;

  logic [OUT_WIDTH-1:0]  out_tdata;
  logic                  out_tvalid;
  logic                  out_tlast;
  logic                  out_tready;

  modport master (
    output in_tdata,
    output in_tvalid,
    output in_tlast,
    input  in_tready,
    input  out_tdata,
    input  out_tvalid,
    input  out_tlast,
    output out_tready
  );

  modport slave (
    input  in_tdata,
    input  in_tvalid,
    input  in_tlast,
    output in_tready,
    output out_tdata,
    output out_tvalid,
    output out_tlast,
    input  out_tready
  );
endinterface

// File: rtl/matrix_row_accumulate.sv
// ---------------------------------------------------------------------------
// matrix_row_accumulate
//
// Streaming reduction stage placed after matrix_transpose. It consumes a
// SIZE x SIZE matrix row-major, one element per beat, and emits one sum per
// row (SIZE sums per matrix, out_tlast on the last). Because the input is
// already transposed, these are the column sums of the original matrix.
//
// Frame alignment is checked against in_tlast: an early tlast closes the
// matrix with a partial row sum, a missing tlast closes it at the natural
// boundary anyway. Either case raises a one-cycle frame_err pulse and the
// row/column counters restart at 0.
//
// Parameters
//   SIZE        matrix dimension, power of two, >= 2
//   DATA_WIDTH  input element width
//   OUT_WIDTH   (local) DATA_WIDTH + $clog2(SIZE); a row sum cannot overflow
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   axis       matrix_row_accumulate_if.slave stream bundle
//   frame_err  one-cycle pulse after a row-end beat whose tlast disagrees
//              with the matrix position
//
// Build option
//   MATRIX_ROW_ACCUMULATE_SIGNED_EN  when defined, elements are two's
//   complement and sign-extended before addition; otherwise zero-extended.
//   Ports and timing are identical in both builds.
// ---------------------------------------------------------------------------
module matrix_row_accumulate #(
  parameter int SIZE       = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  matrix_row_accumulate_if.slave axis,
  output logic                   frame_err
);

  localparam int OUT_WIDTH = DATA_WIDTH + $clog2(SIZE);
  localparam int EXT_BITS  = OUT_WIDTH - DATA_WIDTH;
  localparam int CNT_WIDTH = $clog2(SIZE);
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(SIZE - 1);

  // S_HOLD marks a row-end beat waiting on a full, undrained output stage.
  typedef enum logic [0:0] {
    S_ACC,
    S_HOLD
  } state_t;

  state_t                state;

  logic [OUT_WIDTH-1:0]  acc;
  logic [CNT_WIDTH-1:0]  col;
  logic [CNT_WIDTH-1:0]  row;

  logic [OUT_WIDTH-1:0]  out_data_q;
  logic                  out_valid_q;
  logic                  out_last_q;

  logic [OUT_WIDTH-1:0]  in_ext;
  logic [OUT_WIDTH-1:0]  row_sum;
  logic                  row_end;
  logic                  at_frame_end;
  logic                  sum_last;
  logic                  drain;
  logic                  stall;
  logic                  accept;

  // ---------------------------------------------------------------------
  // Combinational decode of the current beat
  // ---------------------------------------------------------------------
  always_comb begin
`ifdef MATRIX_ROW_ACCUMULATE_SIGNED_EN
    in_ext = {{EXT_BITS{axis.in_tdata[DATA_WIDTH-1]}}, axis.in_tdata};
`else
    in_ext = {{EXT_BITS{1'b0}}, axis.in_tdata};
`endif
    row_sum      = acc + in_ext;

    // A beat closes a row at the last column or whenever tlast is seen.
    row_end      = (col == LAST_IDX) || axis.in_tlast;
    at_frame_end = (col == LAST_IDX) && (row == LAST_IDX);
    sum_last     = (row == LAST_IDX) || axis.in_tlast;

    drain        = out_valid_q && axis.out_tready;

    // Only a row-end beat needs the output stage; it may proceed when the
    // stage is empty or being drained this very cycle (no bubble).
    stall        = row_end && out_valid_q && !axis.out_tready;
    accept       = axis.in_tvalid && !stall;
  end

  assign axis.in_tready  = !stall;
  assign axis.out_tdata  = out_data_q;
  assign axis.out_tvalid = out_valid_q;
  assign axis.out_tlast  = out_last_q;

  // ---------------------------------------------------------------------
  // Accumulator, counters, output holding stage and FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_ACC;
      acc         <= '0;
      col         <= '0;
      row         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      if (drain) begin
        out_valid_q <= 1'b0;
      end

      if (accept) begin
        if (row_end) begin
          // A load in the same cycle as a drain overrides the clear above.
          out_data_q  <= row_sum;
          out_valid_q <= 1'b1;
          out_last_q  <= sum_last;
          acc         <= '0;
          col         <= '0;
          row         <= sum_last ? '0 : row + 1'b1;
          // Covers both early tlast and missing tlast at the frame end.
          frame_err   <= (axis.in_tlast != at_frame_end);
        end else begin
          acc <= row_sum;
          col <= col + 1'b1;
        end
      end

      case (state)
        S_ACC: begin
          if (axis.in_tvalid && stall) begin
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (axis.out_tready) begin
            state <= S_ACC;
          end
        end
        default: state <= S_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_row_accumulate.sv
module tb_matrix_row_accumulate;

  localparam int SIZE  = 4;
  localparam int DW    = 32;
  localparam int OW    = DW + $clog2(SIZE);
  localparam int NELEM = SIZE * SIZE;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  typedef struct {
    logic [OW-1:0] s;
    logic          l;
  } sum_t;

  logic clk_tb;
  logic rst;
  logic frame_err;

  matrix_row_accumulate_if #(.SIZE(SIZE), .DATA_WIDTH(DW)) bus ();

  matrix_row_accumulate #(
    .SIZE       (SIZE),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk_tb),
    .rst       (rst),
    .axis      (bus),
    .frame_err (frame_err)
  );

  initial begin
    clk_tb = 1'b0;
    forever #5 clk_tb = ~clk_tb;
  end

  int    total = 0;
  int    bad   = 0;

  beat_t stim[$];
  sum_t  got[$];
  sum_t  exp_q[$];
  int    exp_err;

  int    err_seen;
  int    stall_cycles;
  int    unstable;
  int    first_stall_idx;
  int    cur_idx;
  logic  rand_ready;

  // Observer: collects handshaken sums, frame_err pulses, input stalls and
  // any change of held output data while the sink is not ready.
  initial begin
    logic          hold_prev;
    logic [OW-1:0] d_prev;
    logic          l_prev;
    sum_t          s;
    hold_prev = 1'b0;
    d_prev    = '0;
    l_prev    = 1'b0;
    forever begin
      @(negedge clk_tb);
      if (rst !== 1'b1) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev && (bus.out_tdata !== d_prev || bus.out_tlast !== l_prev))
          unstable++;
        if (bus.out_tvalid === 1'b1 && bus.out_tready === 1'b1) begin
          s.s = bus.out_tdata;
          s.l = bus.out_tlast;
          got.push_back(s);
        end
        if (frame_err === 1'b1) err_seen++;
        if (bus.in_tvalid === 1'b1 && bus.in_tready !== 1'b1) begin
          stall_cycles++;
          if (first_stall_idx < 0) first_stall_idx = cur_idx;
        end
        hold_prev = (bus.out_tvalid === 1'b1) && (bus.out_tready !== 1'b1);
        d_prev    = bus.out_tdata;
        l_prev    = bus.out_tlast;
      end
    end
  end

  // Random sink readiness, active only while rand_ready is set.
  initial begin
    forever begin
      @(posedge clk_tb);
      #1;
      if (rand_ready) bus.out_tready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Reference model: walks the beat list by matrix position. A row closes
  // at every SIZE-th element of the matrix or on tlast; a matrix closes on
  // tlast or after SIZE*SIZE elements, and a closing that disagrees with
  // tlast counts as a framing error.
  // ---------------------------------------------------------------------
  function automatic longint ext(input logic [DW-1:0] d);
`ifdef MATRIX_ROW_ACCUMULATE_SIGNED_EN
    return longint'($signed(d));
`else
    return longint'({32'd0, d});
`endif
  endfunction

  function automatic void build_expected();
    longint sum;
    int     pos;
    sum_t   e;
    sum = 0;
    pos = 0;
    exp_q.delete();
    exp_err = 0;
    foreach (stim[i]) begin
      sum += ext(stim[i].d);
      if (stim[i].l || (pos % SIZE) == SIZE - 1) begin
        e.s = sum[OW-1:0];
        e.l = stim[i].l || (pos / SIZE) == SIZE - 1;
        exp_q.push_back(e);
        if (stim[i].l != (pos == NELEM - 1)) exp_err++;
        sum = 0;
        pos = e.l ? 0 : pos + 1;
      end else begin
        pos++;
      end
    end
  endfunction

  function automatic void push_seq(input int first, input int n, input logic last_flag);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.d = DW'(first + k);
      b.l = last_flag && (k == n - 1);
      stim.push_back(b);
    end
  endfunction

  function automatic void clear_obs();
    got.delete();
    err_seen        = 0;
    stall_cycles    = 0;
    unstable        = 0;
    first_stall_idx = -1;
    cur_idx         = 0;
  endfunction

  // ---------------------------------------------------------------------
  // Stimulus drivers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------
  task automatic send_stream();
    int   waitc;
    logic done;
    for (int i = 0; i < stim.size(); i++) begin
      waitc         = 0;
      done          = 1'b0;
      cur_idx       = i;
      bus.in_tdata  = stim[i].d;
      bus.in_tlast  = stim[i].l;
      bus.in_tvalid = 1'b1;
      while (!done) begin
        @(negedge clk_tb);
        if (bus.in_tready === 1'b1) begin
          done = 1'b1;
        end else if (waitc >= 300) begin
          total++;
          bad++;
          $display("FAIL accept_timeout beat=%0d in_tready=%b required=1", i, bus.in_tready);
          done = 1'b1;
        end
        waitc++;
        @(posedge clk_tb);
        #1;
      end
    end
    bus.in_tvalid = 1'b0;
    bus.in_tlast  = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    int c;
    c = 0;
    while (got.size() < n && c < 500) begin
      @(posedge clk_tb);
      #1;
      c++;
    end
    repeat (4) begin
      @(posedge clk_tb);
      #1;
    end
  endtask

  // ---------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------
  task automatic test_reset();
    bus.in_tvalid  = 1'b0;
    bus.in_tlast   = 1'b0;
    bus.in_tdata   = '0;
    bus.out_tready = 1'b1;
    rand_ready     = 1'b0;
    rst            = 1'b0;
    clear_obs();
    repeat (3) begin
      @(posedge clk_tb);
      #1;
    end
    @(negedge clk_tb);
    total++;
    if (bus.out_tvalid !== 1'b0) begin
      bad++; $display("FAIL reset_out_tvalid got=%b required=0", bus.out_tvalid);
    end
    total++;
    if (bus.out_tlast !== 1'b0) begin
      bad++; $display("FAIL reset_out_tlast got=%b required=0", bus.out_tlast);
    end
    total++;
    if (bus.out_tdata !== '0) begin
      bad++; $display("FAIL reset_out_tdata got=%0h required=0", bus.out_tdata);
    end
    total++;
    if (frame_err !== 1'b0) begin
      bad++; $display("FAIL reset_frame_err got=%b required=0", frame_err);
    end
    rst = 1'b1;
    @(posedge clk_tb);
    #1;
    total++;
    if (bus.in_tready !== 1'b1) begin
      bad++; $display("FAIL reset_in_tready got=%b required=1", bus.in_tready);
    end
  endtask

  task automatic test_basic_stream();
    logic [OW-1:0] exp_s [SIZE];
    exp_s = '{34'd10, 34'd26, 34'd42, 34'd58};
    stim.delete();
    push_seq(1, NELEM, 1'b1);
    clear_obs();
    send_stream();
    // Last sum appears the cycle after its final element is accepted.
    total++;
    if (bus.out_tvalid !== 1'b1 || bus.out_tdata !== 34'd58 || bus.out_tlast !== 1'b1) begin
      bad++;
      $display("FAIL basic_latency got=v%b/%0d/l%b required=v1/58/l1",
               bus.out_tvalid, bus.out_tdata, bus.out_tlast);
    end
    wait_outputs(SIZE);
    total++;
    if (got.size() != SIZE) begin
      bad++; $display("FAIL basic_count got=%0d required=%0d", got.size(), SIZE);
    end
    for (int i = 0; i < SIZE && i < got.size(); i++) begin
      total++;
      if (got[i].s !== exp_s[i] || got[i].l !== (i == SIZE - 1)) begin
        bad++;
        $display("FAIL basic_sum[%0d] got=%0d/l%b required=%0d/l%b",
                 i, got[i].s, got[i].l, exp_s[i], (i == SIZE - 1));
      end
    end
    total++;
    if (err_seen != 0) begin
      bad++; $display("FAIL basic_frame_err got=%0d required=0", err_seen);
    end
    total++;
    if (stall_cycles != 0) begin
      bad++; $display("FAIL basic_in_tready_stalls got=%0d required=0", stall_cycles);
    end
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] exp_s [SIZE];
    exp_s = '{34'd10, 34'd26, 34'd42, 34'd58};
    stim.delete();
    push_seq(1, NELEM, 1'b1);
    clear_obs();
    bus.out_tready = 1'b0;
    fork
      send_stream();
      begin
        repeat (30) @(posedge clk_tb);
        #1;
        bus.out_tready = 1'b1;
      end
    join
    wait_outputs(SIZE);
    total++;
    if (first_stall_idx != 7) begin
      bad++; $display("FAIL bp_first_stall_elem got=%0d required=7", first_stall_idx);
    end
    total++;
    if (got.size() != SIZE) begin
      bad++; $display("FAIL bp_count got=%0d required=%0d", got.size(), SIZE);
    end
    for (int i = 0; i < SIZE && i < got.size(); i++) begin
      total++;
      if (got[i].s !== exp_s[i] || got[i].l !== (i == SIZE - 1)) begin
        bad++;
        $display("FAIL bp_sum[%0d] got=%0d/l%b required=%0d/l%b",
                 i, got[i].s, got[i].l, exp_s[i], (i == SIZE - 1));
      end
    end
    total++;
    if (unstable != 0) begin
      bad++; $display("FAIL bp_hold_stability got=%0d required=0", unstable);
    end
  endtask

  task automatic test_early_tlast();
    beat_t b;
    stim.delete();
    push_seq(1, 6, 1'b1);
    for (int k = 0; k < NELEM; k++) begin
      b.d = $urandom();
      b.l = (k == NELEM - 1);
      stim.push_back(b);
    end
    build_expected();
    clear_obs();
    send_stream();
    wait_outputs(exp_q.size());
    total++;
    if (got.size() < 2 || got[0].s !== 34'd10 || got[0].l !== 1'b0 ||
        got[1].s !== 34'd11 || got[1].l !== 1'b1) begin
      bad++;
      $display("FAIL early_partial got_n=%0d required=10/l0,11/l1", got.size());
    end
    total++;
    if (err_seen != 1) begin
      bad++; $display("FAIL early_frame_err got=%0d required=1", err_seen);
    end
    total++;
    if (got.size() != exp_q.size()) begin
      bad++; $display("FAIL early_count got=%0d required=%0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++;
      if (got[i].s !== exp_q[i].s || got[i].l !== exp_q[i].l) begin
        bad++;
        $display("FAIL early_sum[%0d] got=%0h/l%b required=%0h/l%b",
                 i, got[i].s, got[i].l, exp_q[i].s, exp_q[i].l);
      end
    end
  endtask

  task automatic test_missing_tlast();
    logic [OW-1:0] exp_s [SIZE];
    exp_s = '{34'd10, 34'd26, 34'd42, 34'd58};
    stim.delete();
    push_seq(1, NELEM, 1'b0);
    push_seq(1, NELEM, 1'b1);
    clear_obs();
    send_stream();
    wait_outputs(2 * SIZE);
    total++;
    if (got.size() != 2 * SIZE) begin
      bad++; $display("FAIL missing_count got=%0d required=%0d", got.size(), 2 * SIZE);
    end
    for (int i = 0; i < 2 * SIZE && i < got.size(); i++) begin
      total++;
      if (got[i].s !== exp_s[i % SIZE] || got[i].l !== ((i % SIZE) == SIZE - 1)) begin
        bad++;
        $display("FAIL missing_sum[%0d] got=%0d/l%b required=%0d/l%b",
                 i, got[i].s, got[i].l, exp_s[i % SIZE], ((i % SIZE) == SIZE - 1));
      end
    end
    total++;
    if (err_seen != 1) begin
      bad++; $display("FAIL missing_frame_err got=%0d required=1", err_seen);
    end
  endtask

  task automatic test_all_ones();
    beat_t b;
    stim.delete();
    for (int k = 0; k < NELEM; k++) begin
      b.d = '1;
      b.l = (k == NELEM - 1);
      stim.push_back(b);
    end
    clear_obs();
    send_stream();
    wait_outputs(SIZE);
    total++;
    if (got.size() != SIZE) begin
      bad++; $display("FAIL ones_count got=%0d required=%0d", got.size(), SIZE);
    end
    // 4 * 0xFFFFFFFF unsigned and -4 signed share the same 34-bit pattern.
    for (int i = 0; i < SIZE && i < got.size(); i++) begin
      total++;
      if (got[i].s !== 34'h3_FFFF_FFFC) begin
        bad++; $display("FAIL ones_sum[%0d] got=%0h required=3fffffffc", i, got[i].s);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [OW-1:0] exp_s [SIZE];
    exp_s = '{34'd10, 34'd26, 34'd42, 34'd58};
    stim.delete();
    push_seq(1, 5, 1'b0);
    clear_obs();
    bus.out_tready = 1'b0;
    send_stream();
    rst = 1'b0;
    @(posedge clk_tb);
    #1;
    total++;
    if (bus.out_tvalid !== 1'b0 || bus.out_tdata !== '0 || bus.out_tlast !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outputs got=v%b/%0d/l%b required=v0/0/l0",
               bus.out_tvalid, bus.out_tdata, bus.out_tlast);
    end
    total++;
    if (bus.in_tready !== 1'b1) begin
      bad++; $display("FAIL midreset_in_tready got=%b required=1", bus.in_tready);
    end
    rst            = 1'b1;
    bus.out_tready = 1'b1;
    @(posedge clk_tb);
    #1;
    stim.delete();
    push_seq(1, NELEM, 1'b1);
    clear_obs();
    send_stream();
    wait_outputs(SIZE);
    total++;
    if (got.size() != SIZE) begin
      bad++; $display("FAIL midreset_count got=%0d required=%0d", got.size(), SIZE);
    end
    for (int i = 0; i < SIZE && i < got.size(); i++) begin
      total++;
      if (got[i].s !== exp_s[i] || got[i].l !== (i == SIZE - 1)) begin
        bad++;
        $display("FAIL midreset_sum[%0d] got=%0d/l%b required=%0d/l%b",
                 i, got[i].s, got[i].l, exp_s[i], (i == SIZE - 1));
      end
    end
    total++;
    if (err_seen != 0) begin
      bad++; $display("FAIL midreset_frame_err got=%0d required=0", err_seen);
    end
  endtask

  task automatic test_random();
    beat_t b;
    int    kind;
    int    len;
    stim.delete();
    for (int f = 0; f < 12; f++) begin
      kind = $urandom_range(0, 9);
      len  = (kind == 0) ? $urandom_range(1, NELEM - 1) : NELEM;
      for (int k = 0; k < len; k++) begin
        b.d = ($urandom_range(0, 1) != 0) ? $urandom() : DW'($urandom_range(0, 255));
        b.l = (k == len - 1) && !(kind == 1 && f != 11);
        stim.push_back(b);
      end
    end
    build_expected();
    clear_obs();
    rand_ready = 1'b1;
    send_stream();
    wait_outputs(exp_q.size());
    rand_ready     = 1'b0;
    bus.out_tready = 1'b1;
    total++;
    if (got.size() != exp_q.size()) begin
      bad++; $display("FAIL rand_count got=%0d required=%0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++;
      if (got[i].s !== exp_q[i].s || got[i].l !== exp_q[i].l) begin
        bad++;
        $display("FAIL rand_sum[%0d] got=%0h/l%b required=%0h/l%b",
                 i, got[i].s, got[i].l, exp_q[i].s, exp_q[i].l);
      end
    end
    total++;
    if (err_seen != exp_err) begin
      bad++; $display("FAIL rand_frame_err got=%0d required=%0d", err_seen, exp_err);
    end
    total++;
    if (unstable != 0) begin
      bad++; $display("FAIL rand_hold_stability got=%0d required=0", unstable);
    end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_early_tlast();
    test_missing_tlast();
    test_all_ones();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
